stream_mux_n: RTL and testbench
===============================

STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 SHALL have parameter SIZE, default 8: data width per channel in bits.
REQ-002 SHALL have parameter CHANNELS, default 4: number of input channels, range 2..16.
REQ-003 SHALL have parameter SEL_W, default 2: select/channel-index width, equal to ceil(log2(CHANNELS)).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, CHANNELS*SIZE: packed channel data; channel i occupies bits [i*SIZE +: SIZE].
REQ-007 SHALL have port in_valid, input, CHANNELS: per-channel data-valid.
REQ-008 SHALL have port in_ready, output, CHANNELS: per-channel accept; at most one bit high per cycle.
REQ-009 SHALL have port sel_mode, input, 1: 1 = forced select via sel; 0 = arbitrated.
REQ-010 SHALL have port sel, input, SEL_W: forced channel index, used only when sel_mode=1.
REQ-011 SHALL have port out_data, output, SIZE: registered selected data.
REQ-012 SHALL have port out_chan, output, SEL_W: index of the channel that out_data came from.
REQ-013 SHALL have port out_valid, output, 1: out_data/out_chan valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accept.

Function
REQ-015 SHALL hold one output register stage; latency from input acceptance to out_valid = 1 cycle.
REQ-016 SHALL treat a transfer as in_valid[i] && in_ready[i] on input, and out_valid && out_ready on output.
REQ-017 SHALL assert in_ready[g] combinationally only for the granted channel g, and only when (!out_valid || out_ready).
REQ-018 SHALL, on input transfer, load out_data = channel g data, out_chan = g, and out_valid = 1 on the next edge.
REQ-019 SHALL, with out_valid=1 and out_ready=0, hold out_data, out_chan and out_valid stable and deassert all in_ready.
REQ-020 SHALL, on output transfer with no simultaneous input transfer, clear out_valid on the next edge.
REQ-021 SHALL, on simultaneous output and input transfer, reload the register (full throughput, 1 word/cycle).
REQ-022 SHALL, with sel_mode=1, set g = sel; if sel >= CHANNELS, grant no channel (all in_ready=0).
REQ-023 SHALL, with sel_mode=1, assert in_ready[sel] only if in_valid[sel]; other channels' valid is ignored.
REQ-024 SHALL, with sel_mode=0, grant per arbitration policy (REQ-030/031) among channels with in_valid=1; none valid -> no grant.
REQ-025 SHALL evaluate sel_mode and sel every cycle; a change takes effect on the same cycle's grant without disturbing a held output word.
REQ-026 SHALL keep the round-robin pointer in range 0..CHANNELS-1, wrapping CHANNELS-1 -> 0.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set out_valid=0, out_data=0, out_chan=0 and round-robin pointer=0.
REQ-028 SHALL force in_ready=0 during any cycle in which rst=1.
REQ-029 SHALL discard a held output word when reset is asserted mid-operation; no word is replayed after reset.

Configuration
REQ-030 SHALL, with macro STREAM_MUX_RR_EN defined, arbitrate round-robin in sel_mode=0: search starts at pointer; after each input transfer the pointer becomes g+1 (wrapped).
REQ-031 SHALL, without STREAM_MUX_RR_EN, arbitrate fixed priority in sel_mode=0: lowest valid index wins; no pointer register is built.

Verification (SIZE=4, CHANNELS=4, SEL_W=2)
REQ-032 SHALL cover reset: rst=1 for 2 cycles, all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_chan=0.
REQ-033 SHALL cover forced select: sel_mode=1, sel=2, in_data ch2=4'd3, in_valid=0100, out_ready=1 -> next cycle out_data=3, out_chan=2, out_valid=1.
REQ-034 SHALL cover backpressure: out_valid=1 holding 4'd5, out_ready=0 for 3 cycles, ch1 data changes 5->7 -> out_data stays 5, in_ready=0000 throughout; out_ready=1 -> out_data=7 next cycle.
REQ-035 SHALL cover arbitration: sel_mode=0, in_valid=1111, data ch0..3=1,2,3,4, out_ready=1 -> with STREAM_MUX_RR_EN out_chan sequence 0,1,2,3,0; without it 0,0,0,0.
REQ-036 SHALL cover invalid select and mid-operation reset: sel_mode=1 with the sel value >= CHANNELS (e.g. CHANNELS=3, sel=3) -> in_ready=000, out_valid stays 0; then with out_valid=1, pulse rst for 1 cycle -> out_valid=0 next cycle and pointer=0.

Source files
------------

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with one registered output stage.
// Define STREAM_MUX_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module stream_mux_n #(
  parameter int SIZE     = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS*SIZE-1:0] in_data,
  input  logic [CHANNELS-1:0]      in_valid,
  output logic [CHANNELS-1:0]      in_ready,
  input  logic                     sel_mode,
  input  logic [SEL_W-1:0]         sel,
  output logic [SIZE-1:0]          out_data,
  output logic [SEL_W-1:0]         out_chan,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [SIZE-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;

  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic             can_accept;
  logic             in_xfer;
  logic [SIZE-1:0]  grant_data;

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;
`endif

  // Grant selection: forced index, or arbitration among valid channels.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (sel_mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
`ifdef STREAM_MUX_RR_EN
      for (int k = 0; k < CHANNELS; k++) begin
        int idx;
        idx = (int'(ptr_q) + k) % CHANNELS;
        if (!grant_valid && in_valid[idx]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(idx);
        end
      end
`else
      for (int i = 0; i < CHANNELS; i++) begin
        if (!grant_valid && in_valid[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
`endif
    end
  end

  always_comb begin
    can_accept = !out_valid_q || out_ready;
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        in_ready[i] = !rst && grant_valid && can_accept;
        grant_data  = in_data[i*SIZE +: SIZE];
      end
    end
    in_xfer = |in_ready;
  end

  // Output stage: reload on input transfer, drain on output transfer, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
    end
  end

`ifdef STREAM_MUX_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (in_xfer) begin
      ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Table-driven self-checking bench for stream_mux_n (4x4-bit main instance, 3-channel instance for invalid select).
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        sel_mode;
  logic [1:0]  sel;
  logic [3:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic        rst3;
  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        sel_mode3;
  logic [1:0]  sel3;
  logic [3:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  stream_mux_n #(.SIZE(4), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel_mode(sel_mode), .sel(sel), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_n #(.SIZE(4), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst3), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .sel_mode(sel_mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  typedef struct packed {
    logic        rst;
    logic        sel_mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic        chk_data;
    logic [3:0]  exp_data;
    logic [1:0]  exp_chan;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector mid-cycle, check the combinational ready, then the registered outputs after the edge.
  task automatic applyStimulus(input string tag, input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    sel_mode  = v.sel_mode;
    sel       = v.sel;
    in_valid  = v.in_valid;
    in_data   = v.in_data;
    out_ready = v.out_ready;
    #1;
    checkOutput({tag, " in_ready"}, 16'(in_ready), 16'(v.exp_ready));
    @(posedge clk);
    #1;
    checkOutput({tag, " out_valid"}, 16'(out_valid), 16'(v.exp_valid));
    if (v.chk_data) begin
      checkOutput({tag, " out_data"}, 16'(out_data), 16'(v.exp_data));
      checkOutput({tag, " out_chan"}, 16'(out_chan), 16'(v.exp_chan));
    end
  endtask

  initial begin
    vec_t v;
    logic [1:0] exp_seq [5];

    rst = 1'b1; sel_mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    rst3 = 1'b1; sel_mode3 = 1'b0; sel3 = '0; in_valid3 = '0; in_data3 = '0; out_ready3 = 1'b0;

    //            rst   mode  sel    in_valid  in_data   ordy  exp_rdy  ov    chk   odata  ochan
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0000, 1'b0, 1'b1, 4'h0, 2'd0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0000, 1'b0, 1'b1, 4'h0, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 16'h0300, 1'b1, 4'b0100, 1'b1, 1'b1, 4'h3, 2'd2};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 4'b0010, 16'h0050, 1'b1, 4'b0010, 1'b1, 1'b1, 4'h5, 2'd1};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 4'b0010, 16'h0070, 1'b0, 4'b0000, 1'b1, 1'b1, 4'h5, 2'd1};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 4'b0010, 16'h0070, 1'b0, 4'b0000, 1'b1, 1'b1, 4'h5, 2'd1};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 4'b0010, 16'h0070, 1'b0, 4'b0000, 1'b1, 1'b1, 4'h5, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 2'd1, 4'b0010, 16'h0070, 1'b1, 4'b0010, 1'b1, 1'b1, 4'h7, 2'd1};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 4'b1101, 16'h4321, 1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 2'd0};
    vecs[9]  = '{1'b0, 1'b1, 2'd3, 4'b1000, 16'h9000, 1'b0, 4'b1000, 1'b1, 1'b1, 4'h9, 2'd3};
    vecs[10] = '{1'b0, 1'b1, 2'd0, 4'b0001, 16'h0001, 1'b0, 4'b0000, 1'b1, 1'b1, 4'h9, 2'd3};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 4'b0100, 16'h0a00, 1'b1, 4'b0100, 1'b1, 1'b1, 4'ha, 2'd2};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'h0, 2'd0};
    vecs[13] = '{1'b0, 1'b0, 2'd0, 4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 2'd0};

    for (int i = 0; i < 14; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Arbitration with every channel valid, starting from a fresh reset.
`ifdef STREAM_MUX_RR_EN
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    v = '{1'b1, 1'b0, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0000, 1'b0, 1'b1, 4'h0, 2'd0};
    applyStimulus("arb_rst", v);
    for (int i = 0; i < 5; i++) begin
      v = '{1'b0, 1'b0, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001 << exp_seq[i], 1'b1, 1'b1,
            4'(exp_seq[i]) + 4'd1, exp_seq[i]};
      applyStimulus($sformatf("arb%0d", i), v);
    end

    // Reset pulse while a word is held under backpressure: word discarded, pointer back to 0.
    v = '{1'b1, 1'b0, 2'd0, 4'b1111, 16'h4321, 1'b0, 4'b0000, 1'b0, 1'b1, 4'h0, 2'd0};
    applyStimulus("midrst", v);
    v = '{1'b0, 1'b0, 2'd0, 4'b0000, 16'h4321, 1'b0, 4'b0000, 1'b0, 1'b1, 4'h0, 2'd0};
    applyStimulus("midrst_noreplay", v);
    v = '{1'b0, 1'b0, 2'd0, 4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 1'b1, 4'h1, 2'd0};
    applyStimulus("midrst_ptr", v);

    // Three-channel instance: select index beyond the channel count grants nothing.
    @(negedge clk);
    rst3 = 1'b0; sel_mode3 = 1'b1; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 12'h654; out_ready3 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checkOutput($sformatf("sel3_bad%0d in_ready", i), 16'(in_ready3), 16'h0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("sel3_bad%0d out_valid", i), 16'(out_valid3), 16'h0);
      @(negedge clk);
    end
    sel3 = 2'd2; in_valid3 = 3'b100;
    #1;
    checkOutput("sel3_ok in_ready", 16'(in_ready3), 16'h4);
    @(posedge clk);
    #1;
    checkOutput("sel3_ok out_valid", 16'(out_valid3), 16'h1);
    checkOutput("sel3_ok out_data", 16'(out_data3), 16'h6);
    checkOutput("sel3_ok out_chan", 16'(out_chan3), 16'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
